// File: rtl/bp_defs.sv
// rtl/bp_defs.sv - shared branch-predictor definitions: counter encodings, PC step, BTB write fields
//
// Purpose: constants and helpers shared by the branch resolve unit and its update queue.
// Ports: none (package).
package bp_defs;

  // 2-bit hysteresis counter encodings
  localparam logic [1:0] CNT_SNT   = 2'd0;
  localparam logic [1:0] CNT_WNT   = 2'd1;
  localparam logic [1:0] CNT_WT    = 2'd2;
  localparam logic [1:0] CNT_ST    = 2'd3;
  localparam logic [1:0] CNT_RESET = CNT_WNT;

  localparam logic [31:0] PC_STEP = 32'd4;

  // BTB write-port field widths
  localparam int BTB_PC_W  = 32;
  localparam int BTB_TGT_W = 32;
  localparam int BTB_WR_W  = BTB_PC_W + BTB_TGT_W;

  typedef struct packed {
    logic [BTB_PC_W-1:0]  pc;
    logic [BTB_TGT_W-1:0] target;
  } btb_wr_t;

  // Saturating counter step toward the observed outcome.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] r;
    r = cnt;
    if (taken) begin
      if (cnt != CNT_ST) r = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) r = cnt - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/update_fifo.sv
// rtl/update_fifo.sv - show-ahead FIFO buffering BTB install requests
//
// Purpose: small show-ahead FIFO between EX and the BTB write port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     enqueue request and payload
//   pop                 dequeue request (ignored when empty)
//   pop_data            head entry (valid when !empty)
//   full, empty         occupancy flags
//   drop                push rejected this cycle (full with no simultaneous pop)
module update_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  logic         do_push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && !do_push;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, redirect and BTB training
//
// Purpose: resolves branches/jumps, compares against the fetch-time BTB prediction,
// issues a registered one-cycle redirect on mispredict, and trains the BTB through a
// 2-bit hysteresis filter and a small update queue.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ex_valid/ex_pc/ex_is_branch/ex_is_jump/ex_taken/ex_target   resolved EX instruction
//   ex_pred_hit/ex_pred_target    BTB prediction carried from fetch
//   redirect_valid/redirect_pc    registered mispredict pulse and correct next PC
//   btb_wr_valid/btb_wr_pc/btb_wr_target/btb_wr_ready   BTB write stream
//   uq_drop                       registered pulse: install dropped, queue full
//   branch_cnt/mispred_cnt        wrapping statistics
module branch_resolve_unit
  import bp_defs::*;
#(
  parameter int CNT_ENTRIES = 64,
  parameter int UQ_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_hit,
  input  logic [31:0] ex_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        btb_wr_valid,
  output logic [31:0] btb_wr_pc,
  output logic [31:0] btb_wr_target,
  input  logic        btb_wr_ready,
  output logic        uq_drop,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(CNT_ENTRIES);

  logic [1:0]       cnt_tbl [CNT_ENTRIES];
  logic [IDX_W-1:0] cnt_idx;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_new;

  logic             qual;
  logic             is_ctl;
  logic             act_taken;
  logic             tgt_miss;
  logic             mispred;
  logic [31:0]      fix_pc;
  logic             install;

  btb_wr_t          push_entry;
  btb_wr_t          head_entry;
  logic             uq_full;
  logic             uq_empty;
  logic             uq_pop;
  logic             uq_drop_now;

  // The instruction in EX during a redirect cycle is on the wrong path.
  assign qual      = ex_valid && !redirect_valid;
  assign is_ctl    = ex_is_branch || ex_is_jump;
  assign act_taken = ex_is_jump || (ex_is_branch && ex_taken);
  assign tgt_miss  = !ex_pred_hit || (ex_pred_target != ex_target);

  assign cnt_idx   = ex_pc[IDX_W+1:2];
  assign cnt_cur   = cnt_tbl[cnt_idx];

  always_comb begin
    cnt_new = cnt_cur;
    if (ex_is_jump)        cnt_new = CNT_ST;
    else if (ex_is_branch) cnt_new = cnt_step(cnt_cur, ex_taken);
  end

  always_comb begin
    mispred = 1'b0;
    fix_pc  = '0;
    if (qual) begin
      if (act_taken && tgt_miss) begin
        mispred = 1'b1;
        fix_pc  = ex_target;
      end else if (!act_taken && ex_pred_hit) begin
        // Not-taken branch or a non-control instruction aliasing a BTB entry.
        mispred = 1'b1;
        fix_pc  = ex_pc + PC_STEP;
      end
    end
  end

  // Branches install only once the filter leans taken; the BTB cannot invalidate,
  // so not-taken outcomes never write.
  assign install = qual && tgt_miss &&
                   (ex_is_jump || (ex_is_branch && ex_taken && (cnt_new >= CNT_WT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CNT_ENTRIES; i++) cnt_tbl[i] <= CNT_RESET;
    end else if (qual && is_ctl) begin
      cnt_tbl[cnt_idx] <= cnt_new;
    end
  end

  assign push_entry.pc     = ex_pc;
  assign push_entry.target = ex_target;
  assign uq_pop            = btb_wr_valid && btb_wr_ready;

  update_fifo #(
    .W     (BTB_WR_W),
    .DEPTH (UQ_DEPTH)
  ) u_update_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (install),
    .push_data (push_entry),
    .pop       (uq_pop),
    .pop_data  (head_entry),
    .full      (uq_full),
    .empty     (uq_empty),
    .drop      (uq_drop_now)
  );

  // Head is gated so the write port reads zero while nothing is queued.
  assign btb_wr_valid  = !uq_empty;
  assign btb_wr_pc     = uq_empty ? '0 : head_entry.pc;
  assign btb_wr_target = uq_empty ? '0 : head_entry.target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      uq_drop        <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      redirect_valid <= mispred;
      redirect_pc    <= fix_pc;
      uq_drop        <= uq_drop_now;
      if (qual && is_ctl) branch_cnt <= branch_cnt + 32'd1;
      if (mispred)        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // Kept visible for debug probes; full is otherwise only consumed inside the FIFO.
  logic uq_full_dbg;
  assign uq_full_dbg = uq_full;

endmodule
